// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential three-digit BCD (000..299) to 9-bit binary
// converter using reverse double-dabble. Each SHIFT cycle shifts the
// {BCD, accumulator} pair right by one bit and then subtracts 3 from any
// BCD nibble that is 8 or more. Nine iterations give the full result.
//
// Optional feature macro: BCD_CHECK_EN
//   defined   : invalid digits are caught at acceptance. The request ends
//               after one cycle with err=1 and bin unchanged.
//   undefined : err is tied low. Invalid digits still finish in 9 clocks.
module bcd_to_binary (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [8:0] bin,
    output logic       err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_bcd;
    logic [8:0] r_acc;
    logic [3:0] r_cnt;
    logic [9:0] w_bcd_tmp;
    logic [9:0] w_bcd_shift;
    logic [8:0] w_acc_shift;
    logic       w_accept;
    logic       w_abort;

    // Reverse double-dabble digit correction: a nibble of 8 or more after
    // the right shift has received a "ten" from above, so remove 3.
    function automatic logic [3:0] f_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd8) begin
            res = nib - 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

`ifdef BCD_CHECK_EN
    logic r_bad;
    logic w_invalid;

    assign w_invalid = (tens > 4'd9) || (ones > 4'd9) || (hundreds == 2'd3);
    assign w_abort   = r_bad;

    // Invalid-digit tracking: latch the check at acceptance, report at edge 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad <= 1'b0;
            err   <= 1'b0;
        end else if (w_accept) begin
            r_bad <= w_invalid;
            err   <= 1'b0;
        end else if ((r_state == ST_SHIFT) && r_bad) begin
            r_bad <= 1'b0;
            err   <= 1'b1;
        end else begin
            r_bad <= r_bad;
            err   <= err;
        end
    end
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // One shift step: the ones LSB enters the accumulator MSB, then fix digits.
    always_comb begin
        w_bcd_tmp   = {1'b0, r_bcd[9:1]};
        w_bcd_shift = {w_bcd_tmp[9:8], f_adjust(w_bcd_tmp[7:4]), f_adjust(w_bcd_tmp[3:0])};
        w_acc_shift = {r_bcd[0], r_acc[8:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, leave SHIFT after the 9th step or an abort.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_abort || (r_cnt == 4'd8)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= 10'd0;
            r_acc <= 9'd0;
            r_cnt <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= 9'd0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_bcd <= {hundreds, tens, ones};
                r_acc <= 9'd0;
                r_cnt <= 4'd0;
                busy  <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                if (w_abort) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    r_bcd <= w_bcd_shift;
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd8) begin
                        bin  <= w_acc_shift;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: table of fixed vectors, hand
// sequences for the multi-cycle corners, and randomized digits checked
// against the decimal value H*100 + T*10 + O.
module tb_bcd_to_binary;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [8:0] bin;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[8];

    bcd_to_binary dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done),
        .bin      (bin),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int h, input int t, input int o);
        return h * 100 + t * 10 + o;
    endfunction

    // Request a conversion (called away from a clock edge with the FSM idle).
    // Returns the number of edges after acceptance until done, or -1.
    task automatic convert(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                           input bit scramble, output int lat);
        logic [8:0] bin_before;
        bit         moved;
        bin_before = bin;
        moved      = 1'b0;
        hundreds   = h;
        tens       = t;
        ones       = o;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            hundreds = 2'd0;
            tens     = 4'd0;
            ones     = 4'd0;
        end
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (bin !== bin_before) moved = 1'b1;
        end
        chk("bin_stable_while_busy", {31'd0, moved}, 32'd0);
    endtask

    // Common checks after a normal conversion has signalled done.
    task automatic finish_checks(input string name, input int lat, input logic [8:0] exp);
        chk({name, "_latency"}, lat, 32'd9);
        chk({name, "_bin"}, {23'd0, bin}, {23'd0, exp});
        chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({name, "_err"}, {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int         lat;
        int         ndone;
        logic [1:0] rh;
        logic [3:0] rt;
        logic [3:0] ro;

        vecs[0] = '{2'd0, 4'd0, 4'd0, 9'd0};
        vecs[1] = '{2'd2, 4'd9, 4'd9, 9'd299};
        vecs[2] = '{2'd0, 4'd4, 4'd2, 9'd42};
        vecs[3] = '{2'd1, 4'd0, 4'd0, 9'd100};
        vecs[4] = '{2'd0, 4'd9, 4'd9, 9'd99};
        vecs[5] = '{2'd2, 4'd0, 4'd1, 9'd201};
        vecs[6] = '{2'd2, 4'd5, 4'd6, 9'd256};
        vecs[7] = '{2'd0, 4'd0, 4'd1, 9'd1};

        rst_n    = 1'b0;
        start    = 1'b0;
        hundreds = 2'd0;
        tens     = 4'd0;
        ones     = 4'd0;
        #22;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_bin", {23'd0, bin}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].h, vecs[i].t, vecs[i].o, 1'b0, lat);
            finish_checks("vec", lat, vecs[i].exp);
        end

        // Inputs changed during SHIFT must not affect the result.
        convert(2'd1, 4'd2, 4'd8, 1'b1, lat);
        finish_checks("scramble", lat, 9'd128);

        // start held high during busy: one done only, then restart in done cycle.
        hundreds = 2'd0;
        tens     = 4'd3;
        ones     = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("held_start_one_done", ndone, 32'd1);
        chk("held_start_bin", {23'd0, bin}, 32'd33);
        hundreds = 2'd0;
        tens     = 4'd5;
        ones     = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_dropped", {31'd0, done}, 32'd0);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        finish_checks("b2b", lat, 9'd55);

        // Reset mid-conversion aborts at once.
        hundreds = 2'd2;
        tens     = 4'd5;
        ones     = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bin", {23'd0, bin}, 32'd0);
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        convert(2'd0, 4'd4, 4'd2, 1'b0, lat);
        finish_checks("after_abort", lat, 9'd42);

        // Randomized valid digits against the decimal model.
        for (int i = 0; i < 16; i++) begin
            rh = 2'($urandom_range(0, 2));
            rt = 4'($urandom_range(0, 9));
            ro = 4'($urandom_range(0, 9));
            convert(rh, rt, ro, 1'b0, lat);
            finish_checks("rand", lat, 9'(model(int'(rh), int'(rt), int'(ro))));
        end

`ifdef BCD_CHECK_EN
        // Invalid digit: one-cycle request, err set, bin unchanged.
        convert(2'd0, 4'd10, 4'd0, 1'b0, lat);
        chk("invalid_latency", lat, 32'd1);
        chk("invalid_err", {31'd0, err}, 32'd1);
        chk("invalid_busy_low", {31'd0, busy}, 32'd0);
        chk("invalid_bin_kept", {23'd0, bin}, {23'd0, 9'(model(int'(rh), int'(rt), int'(ro)))});
        @(posedge clk);
        #1;
        chk("invalid_err_holds", {31'd0, err}, 32'd1);
        convert(2'd0, 4'd0, 4'd7, 1'b0, lat);
        finish_checks("after_invalid", lat, 9'd7);
`else
        // Invalid digits still finish in 9 clocks with err low.
        convert(2'd3, 4'd12, 4'd15, 1'b0, lat);
        chk("invalid_latency", lat, 32'd9);
        chk("invalid_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        convert(2'd0, 4'd0, 4'd7, 1'b0, lat);
        finish_checks("after_invalid", lat, 9'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
